// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op encodings, instruction layout and sequencer state encoding
package alu_seq_pkg;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
      OP_XOR = 3'b100, OP_SLL = 3'b101, OP_SRL = 3'b110, OP_SRA = 3'b111
   } alu_op_e;
   // Field order matches the packed word: [15]=NOP, [14:12]=op, [11:8]=Rs, [7:4]=Rt, [3:0]=Rd
   typedef struct packed {
      logic       nop;
      alu_op_e    op;
      logic [3:0] rs;
      logic [3:0] rt;
      logic [3:0] rd;
   } instr_t;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_GAP = 2'd2} seq_state_e;
endpackage

// File: rtl/seq_instr_fifo.sv
// seq_instr_fifo: DEPTH x W instruction buffer; ports clk, rst, push, pop, din, dout (head), count, full, empty
module seq_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;
   always_comb begin
      full     = count_q == (AW+1)'(DEPTH);
      empty    = count_q == '0;
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      dout     = mem_q[rd_ptr_q];
      count    = count_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: buffers 16-bit ALU words and issues them as fixed-length execute pulses with an idle gap
// Ports: clk/rst, instr_in/instr_valid/instr_ready push side, run, alu_op/rs_addr/rt_addr/rd_addr/execute to the ALU top, busy, fifo_count
// Option SEQ_RETIRE_CNT_EN adds retire_count (16-bit count of completed non-NOP instructions)
module alu_instr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int EXEC_CYCLES = 2,
   parameter int GAP_CYCLES  = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [15:0]                 instr_in,
   input  logic                        instr_valid,
   output logic                        instr_ready,
   input  logic                        run,
   output logic [2:0]                  alu_op,
   output logic [3:0]                  rs_addr,
   output logic [3:0]                  rt_addr,
   output logic [3:0]                  rd_addr,
   output logic                        execute,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef SEQ_RETIRE_CNT_EN
   ,
   output logic [15:0]                 retire_count
`endif
);
   localparam int CW = $clog2(EXEC_CYCLES + GAP_CYCLES + 1) + 1;
   seq_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   alu_op_e      op_q, op_d;
   logic [3:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic         exec_q, exec_d;
   logic         pop, full, empty;
   logic [15:0]  head;
   instr_t       hd;
`ifdef SEQ_RETIRE_CNT_EN
   logic [15:0]  retire_q, retire_d;
   assign retire_count = retire_q;
`endif
   seq_instr_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
      .clk(clk), .rst(rst), .push(instr_valid), .pop(pop), .din(instr_in),
      .dout(head), .count(fifo_count), .full(full), .empty(empty)
   );
   assign hd          = instr_t'(head);
   assign instr_ready = ~full;
   assign alu_op      = op_q;
   assign rs_addr     = rs_q;
   assign rt_addr     = rt_q;
   assign rd_addr     = rd_q;
   assign execute     = exec_q;
   assign busy        = state_q != S_IDLE;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      exec_d  = exec_q;
      pop     = 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
      retire_d = retire_q;
`endif
      case (state_q)
         S_IDLE: if (run && !empty) begin
            pop = 1'b1;
            // NOP words are consumed here and never reach the ALU
            if (!hd.nop) begin
               op_d    = hd.op;
               rs_d    = hd.rs;
               rt_d    = hd.rt;
               rd_d    = hd.rd;
               exec_d  = 1'b1;
               cnt_d   = CW'(1);
               state_d = S_EXEC;
            end
         end
         S_EXEC: if (cnt_q == CW'(EXEC_CYCLES)) begin
            exec_d  = 1'b0;
            cnt_d   = CW'(1);
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
`ifdef SEQ_RETIRE_CNT_EN
            retire_d = retire_q + 16'd1;
`endif
         end else cnt_d = cnt_q + CW'(1);
         S_GAP: if (cnt_q == CW'(GAP_CYCLES)) state_d = S_IDLE;
                else cnt_d = cnt_q + CW'(1);
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_ADD;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         exec_q  <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
         retire_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         exec_q  <= exec_d;
`ifdef SEQ_RETIRE_CNT_EN
         retire_q <= retire_d;
`endif
      end
   end
endmodule
